// File: rtl/decode_operand_stage.sv
// Decode/operand-fetch stage: register-file read selects, same-cycle writeback
// bypass, scoreboard-based RAW/WAW stall and a single-entry output slot to execute.
module decode_operand_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  rf_ra,
  output logic [4:0]  rf_rb,
  input  logic [31:0] rf_bus_a,
  input  logic [31:0] rf_bus_b,
  input  logic        wb_we,
  input  logic [4:0]  wb_rw,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [5:0]  out_opcode,
  output logic [4:0]  out_rd,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [31:0] out_imm
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // slot holds its payload stable while out_valid && !out_ready, and in_ready
  // never depends on in_valid.

  logic [4:0]  rs1, rs2, rd;
  logic [31:0] scoreboard;
  logic [31:0] slot_mask, pending;
  logic [31:0] sb_set, sb_clr;
  logic        hit_rs1, hit_rs2, hit_rd;
  logic        raw, waw, hold, hazard;
  logic        accept, handoff;
  logic [31:0] opnd_a, opnd_b, imm_ext;

  assign rs1   = in_instr[20:16];
  assign rs2   = in_instr[15:11];
  assign rd    = in_instr[25:21];
  assign rf_ra = rs1;
  assign rf_rb = rs2;

  // The instruction sitting in the slot has not reached the scoreboard yet,
  // so its destination counts as pending too; r0 is never pending.
  assign slot_mask = out_valid ? (32'd1 << out_rd) : 32'd0;
  assign pending   = (scoreboard | slot_mask) & ~32'd1;

  assign hit_rs1 = wb_we && (wb_rw == rs1);
  assign hit_rs2 = wb_we && (wb_rw == rs2);
  assign hit_rd  = wb_we && (wb_rw == rd);

  assign raw  = ((rs1 != 5'd0) && pending[rs1] && !hit_rs1) ||
                ((rs2 != 5'd0) && pending[rs2] && !hit_rs2);
  assign waw  = (rd != 5'd0) && pending[rd] && !hit_rd;
  // The register file buses are unusable while a write is in progress, so any
  // nonzero source not covered by the bypass has to wait a cycle.
  assign hold = wb_we && (((rs1 != 5'd0) && !hit_rs1) || ((rs2 != 5'd0) && !hit_rs2));
  assign hazard = raw || waw || hold;

  assign in_ready = !reset && !hazard && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid && out_ready;

  assign opnd_a  = (rs1 == 5'd0) ? 32'd0 : (hit_rs1 ? wb_data : rf_bus_a);
  assign opnd_b  = (rs2 == 5'd0) ? 32'd0 : (hit_rs2 ? wb_data : rf_bus_b);
  assign imm_ext = {{16{in_instr[15]}}, in_instr[15:0]};

  assign sb_set = (handoff && (out_rd != 5'd0)) ? (32'd1 << out_rd) : 32'd0;
  assign sb_clr = (wb_we && (wb_rw != 5'd0)) ? (32'd1 << wb_rw) : 32'd0;

  always_ff @(posedge clock) begin
    if (reset) begin
      scoreboard <= 32'd0;
      out_valid  <= 1'b0;
      out_pc     <= 32'd0;
      out_opcode <= 6'd0;
      out_rd     <= 5'd0;
      out_a      <= 32'd0;
      out_b      <= 32'd0;
      out_imm    <= 32'd0;
    end else begin
      // A newly issued writer wins over a writeback to the same register.
      scoreboard <= (scoreboard & ~sb_clr) | sb_set;
      if (flush)        out_valid <= 1'b0;
      else if (accept)  out_valid <= 1'b1;
      else if (handoff) out_valid <= 1'b0;
      if (accept) begin
        out_pc     <= in_pc;
        out_opcode <= in_instr[31:26];
        out_rd     <= rd;
        out_a      <= opnd_a;
        out_b      <= opnd_b;
        out_imm    <= imm_ext;
      end
    end
  end

endmodule

// File: tb/tb_decode_operand_stage.sv
// Bench for decode_operand_stage: the bench plays register file and execute unit,
// and predicts stalls and slot contents from a list of in-flight destinations.
module tb_decode_operand_stage;

  logic        clock, reset;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  rf_ra, rf_rb;
  logic [31:0] rf_bus_a, rf_bus_b;
  logic        wb_we;
  logic [4:0]  wb_rw;
  logic [31:0] wb_data;
  logic        flush, out_valid, out_ready;
  logic [31:0] out_pc;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [31:0] out_a, out_b, out_imm;

  int errors = 0;
  int checks = 0;

  // Reference state: register file contents, destinations handed to execute
  // and not yet written back, and the expected output slot.
  logic [31:0] regfile [32];
  logic [4:0]  exp_q[$];
  logic        exp_valid;
  logic [31:0] exp_pc, exp_a, exp_b, exp_imm;
  logic [5:0]  exp_op;
  logic [4:0]  exp_rd;

  decode_operand_stage dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_bus_a(rf_bus_a), .rf_bus_b(rf_bus_b),
    .wb_we(wb_we), .wb_rw(wb_rw), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_a(out_a), .out_b(out_b),
    .out_imm(out_imm)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] d,
                                     input logic [4:0] s1, input logic [4:0] s2,
                                     input logic [10:0] lo);
    return {op, d, s1, s2, lo};
  endfunction

  function automatic bit pend(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (exp_valid && exp_rd == r) return 1'b1;
    foreach (exp_q[i]) if (exp_q[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit writing(input logic [4:0] r);
    return wb_we && (wb_rw == r);
  endfunction

  function automatic bit model_ready();
    logic [4:0] s1, s2, d;
    bit hz;
    s1 = in_instr[20:16];
    s2 = in_instr[15:11];
    d  = in_instr[25:21];
    hz = (pend(s1) && !writing(s1)) || (pend(s2) && !writing(s2)) ||
         (pend(d) && !writing(d));
    if (wb_we && ((s1 != 5'd0 && s1 != wb_rw) || (s2 != 5'd0 && s2 != wb_rw))) hz = 1'b1;
    return !reset && !hz && !flush && (!exp_valid || out_ready);
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] s);
    if (s == 5'd0) return 32'd0;
    if (writing(s)) return wb_data;
    return regfile[s];
  endfunction

  // The register file's read data is garbage during a write cycle.
  task automatic update_bus();
    rf_bus_a = wb_we ? $urandom() : regfile[in_instr[20:16]];
    rf_bus_b = wb_we ? $urandom() : regfile[in_instr[15:11]];
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic we, input logic [4:0] rw, input logic [31:0] data,
                       input logic fl, input logic ordy);
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    wb_we     = we;
    wb_rw     = rw;
    wb_data   = data;
    flush     = fl;
    out_ready = ordy;
    update_bus();
    #2;
  endtask

  task automatic tick();
    bit acc, ho;
    logic [31:0] na, nb, npc, nimm;
    logic [5:0]  nop;
    logic [4:0]  nrd;
    acc  = in_valid && model_ready();
    ho   = exp_valid && out_ready;
    na   = operand(in_instr[20:16]);
    nb   = operand(in_instr[15:11]);
    npc  = in_pc;
    nop  = in_instr[31:26];
    nrd  = in_instr[25:21];
    nimm = 32'($signed(in_instr[15:0]));
    @(posedge clock);
    if (wb_we && wb_rw != 5'd0) regfile[wb_rw] = wb_data;
    if (reset) begin
      exp_q.delete();
      exp_valid = 1'b0;
      exp_pc = 32'd0; exp_op = 6'd0; exp_rd = 5'd0;
      exp_a = 32'd0; exp_b = 32'd0; exp_imm = 32'd0;
    end else begin
      if (wb_we && wb_rw != 5'd0)
        for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i] == wb_rw) exp_q.delete(i);
      if (ho && exp_rd != 5'd0) exp_q.push_back(exp_rd);
      if (flush) exp_valid = 1'b0;
      else if (acc) begin
        exp_valid = 1'b1;
        exp_pc = npc; exp_op = nop; exp_rd = nrd;
        exp_a = na; exp_b = nb; exp_imm = nimm;
      end else if (ho) exp_valid = 1'b0;
    end
    #1;
    update_bus();
    #1;
  endtask

  // Let the slot drain and write back everything still in flight.
  task automatic drain();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    tick();
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
      drive(1'b0, 32'd0, 32'd0, 1'b1, exp_q[0], $urandom(), 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, mk(6'h03, 5'd5, 5'd1, 5'd2, 11'd0), 32'h40, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    tick();
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if ({out_pc, out_opcode, out_rd, out_a, out_b, out_imm} !== '0) begin
      errors++; $display("FAIL reset_slot got pc=%h op=%h rd=%0d a=%h b=%h imm=%h exp all zero",
                         out_pc, out_opcode, out_rd, out_a, out_b, out_imm);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    regfile[1] = 32'd7;
    regfile[2] = 32'd9;
    drive(1'b1, mk(6'h0a, 5'd5, 5'd1, 5'd2, 11'd0), 32'h100, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got=%b exp=1", in_ready); end
    checks++; if ({rf_ra, rf_rb} !== {5'd1, 5'd2}) begin
      errors++; $display("FAIL basic_rf_sel got ra=%0d rb=%0d exp ra=1 rb=2", rf_ra, rf_rb);
    end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
    checks++; if ({out_a, out_b} !== {32'd7, 32'd9}) begin
      errors++; $display("FAIL basic_operands got a=%h b=%h exp a=7 b=9", out_a, out_b);
    end
    checks++; if ({out_rd, out_opcode, out_pc} !== {5'd5, 6'h0a, 32'h100}) begin
      errors++; $display("FAIL basic_fields got rd=%0d op=%h pc=%h exp rd=5 op=0a pc=100", out_rd, out_opcode, out_pc);
    end
    drain();
  endtask

  task automatic test_bypass();
    drive(1'b1, mk(6'h0b, 5'd3, 5'd1, 5'd0, 11'h7), 32'h104, 1'b1, 5'd1, 32'h55, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bypass_in_ready got=%b exp=1", in_ready); end
    tick();
    checks++; if ({out_a, out_b, out_imm} !== {32'h55, 32'h0, 32'h7}) begin
      errors++; $display("FAIL bypass_operands got a=%h b=%h imm=%h exp a=55 b=0 imm=7", out_a, out_b, out_imm);
    end
    drain();
  endtask

  task automatic test_read_hold();
    drive(1'b1, mk(6'h0c, 5'd3, 5'd1, 5'd0, 11'h0), 32'h108, 1'b1, 5'd4, 32'hab, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready got=%b exp=0", in_ready); end
    tick();
    drive(1'b1, mk(6'h0c, 5'd3, 5'd1, 5'd0, 11'h0), 32'h108, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release got=%b exp=1", in_ready); end
    tick();
    checks++; if (out_a !== regfile[1]) begin
      errors++; $display("FAIL hold_operand got a=%h exp a=%h", out_a, regfile[1]);
    end
    drain();
  endtask

  task automatic test_raw();
    logic [31:0] cons;
    cons = mk(6'h02, 5'd7, 5'd6, 5'd0, 11'h0);
    drive(1'b1, mk(6'h01, 5'd6, 5'd0, 5'd0, 11'h0), 32'h200, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_producer got=%b exp=1", in_ready); end
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, cons, 32'h204, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall cycle=%0d got=%b exp=0", k, in_ready); end
      tick();
    end
    drive(1'b1, cons, 32'h204, 1'b1, 5'd6, 32'h1234, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_resolve got=%b exp=1", in_ready); end
    tick();
    checks++; if ({out_a, out_rd} !== {32'h1234, 5'd7}) begin
      errors++; $display("FAIL raw_capture got a=%h rd=%0d exp a=1234 rd=7", out_a, out_rd);
    end
    drive(1'b1, mk(6'h03, 5'd0, 5'd6, 5'd0, 11'h0), 32'h208, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_sb_clear got=%b exp=1", in_ready); end
    tick();
    drain();
  endtask

  task automatic test_backpressure_waw();
    logic [31:0] w;
    w = mk(6'h06, 5'd6, 5'd0, 5'd0, 11'h0);
    drive(1'b1, mk(6'h04, 5'd6, 5'd1, 5'd2, 11'h0), 32'h300, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, mk(6'h05, 5'd8, 5'd0, 5'd0, 11'h0), 32'h304, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle=%0d got=%b exp=0", k, in_ready); end
      checks++; if ({out_valid, out_pc, out_opcode, out_rd, out_a, out_b} !==
                    {1'b1, exp_pc, exp_op, exp_rd, exp_a, exp_b} || out_pc !== 32'h300) begin
        errors++; $display("FAIL bp_hold cycle=%0d got pc=%h rd=%0d a=%h b=%h exp pc=%h rd=%0d a=%h b=%h",
                           k, out_pc, out_rd, out_a, out_b, exp_pc, exp_rd, exp_a, exp_b);
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, w, 32'h308, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL waw_stall cycle=%0d got=%b exp=0", k, in_ready); end
      tick();
    end
    drive(1'b1, w, 32'h308, 1'b1, 5'd6, 32'h66, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL waw_resolve got=%b exp=1", in_ready); end
    tick();
    checks++; if ({out_valid, out_rd, out_opcode} !== {1'b1, 5'd6, 6'h06}) begin
      errors++; $display("FAIL waw_capture got v=%b rd=%0d op=%h exp v=1 rd=6 op=06", out_valid, out_rd, out_opcode);
    end
    drain();
  endtask

  task automatic test_flush();
    drive(1'b1, mk(6'h07, 5'd0, 5'd0, 5'd0, 11'h0), 32'h400, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, mk(6'h08, 5'd0, 5'd0, 5'd0, 11'h0), 32'h404, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    drive(1'b1, mk(6'h09, 5'd9, 5'd0, 5'd0, 11'h0), 32'h408, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    tick();
    drive(1'b1, mk(6'h0a, 5'd0, 5'd9, 5'd0, 11'h0), 32'h40c, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_handoff_sb got=%b exp=0", in_ready); end
    tick();
    drive(1'b1, mk(6'h0a, 5'd0, 5'd9, 5'd0, 11'h0), 32'h40c, 1'b1, 5'd9, 32'h99, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_wb_release got=%b exp=1", in_ready); end
    tick();
    drain();
  endtask

  task automatic test_reset_stall();
    logic [31:0] cons;
    cons = mk(6'h0e, 5'd2, 5'd6, 5'd0, 11'h0);
    drive(1'b1, mk(6'h0d, 5'd6, 5'd0, 5'd0, 11'h0), 32'h500, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    tick();
    drive(1'b1, cons, 32'h504, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rststall_stall got=%b exp=0", in_ready); end
    tick();
    reset = 1'b1;
    drive(1'b1, cons, 32'h504, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    tick();
    checks++; if ({in_ready, out_valid, out_pc, out_opcode, out_rd, out_a, out_b, out_imm} !== '0) begin
      errors++; $display("FAIL rststall_outputs got rdy=%b v=%b pc=%h rd=%0d exp all zero", in_ready, out_valid, out_pc, out_rd);
    end
    reset = 1'b0;
    drive(1'b1, cons, 32'h504, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rststall_sb_zero got=%b exp=1", in_ready); end
    tick();
    drain();
  endtask

  task automatic test_random();
    logic [31:0] instr;
    logic        we;
    logic [4:0]  rw, s2;
    bit          exp_rdy;
    for (int n = 0; n < 800; n++) begin
      s2 = 5'($urandom_range(0, 7)) | (5'($urandom_range(0, 1)) << 4);
      instr = mk(6'($urandom_range(0, 63)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 s2, 11'($urandom_range(0, 2047)));
      if (exp_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        we = 1'b1;
        rw = exp_q[$urandom_range(0, exp_q.size() - 1)];
      end else if ($urandom_range(0, 7) == 0) begin
        we = 1'b1;
        rw = 5'($urandom_range(0, 31));
      end else begin
        we = 1'b0;
        rw = 5'd0;
      end
      drive($urandom_range(0, 3) != 0, instr, $urandom(), we, rw, $urandom(),
            $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
      exp_rdy = model_ready();
      checks++; if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL rand_in_ready n=%0d got=%b exp=%b", n, in_ready, exp_rdy);
      end
      checks++; if ({rf_ra, rf_rb} !== {instr[20:16], instr[15:11]}) begin
        errors++; $display("FAIL rand_rf_sel n=%0d got ra=%0d rb=%0d exp ra=%0d rb=%0d", n, rf_ra, rf_rb, instr[20:16], instr[15:11]);
      end
      checks++; if (out_valid !== exp_valid) begin
        errors++; $display("FAIL rand_out_valid n=%0d got=%b exp=%b", n, out_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if ({out_pc, out_opcode, out_rd, out_a, out_b, out_imm} !== {exp_pc, exp_op, exp_rd, exp_a, exp_b, exp_imm}) begin
          errors++; $display("FAIL rand_slot n=%0d got pc=%h op=%h rd=%0d a=%h b=%h imm=%h exp pc=%h op=%h rd=%0d a=%h b=%h imm=%h",
                             n, out_pc, out_opcode, out_rd, out_a, out_b, out_imm,
                             exp_pc, exp_op, exp_rd, exp_a, exp_b, exp_imm);
        end
      end
      tick();
    end
    drain();
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    for (int r = 0; r < 32; r++) regfile[r] = $urandom();
    regfile[0] = 32'd0;
    exp_valid = 1'b0;
    reset = 1'b1;
    test_reset();
    test_basic();
    test_bypass();
    test_read_hold();
    test_raw();
    test_backpressure_waw();
    test_flush();
    test_reset_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_operand_stage.md
# decode_operand_stage

Decode/operand-fetch stage between instruction fetch and execute. It drives the register file read selects from the incoming instruction and bypasses same-cycle writebacks. A scoreboard of in-flight destination registers stalls RAW and WAW hazards. Operands, immediate and destination are registered into a single-entry valid/ready output slot feeding execute.

## Interface
Parameters:
- none; widths fixed: 32-bit data/instruction, 5-bit register index, 32 registers

Ports:
- `clock`  in  1  sole clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  `in_instr`/`in_pc` valid
- `in_ready`  out  1  instruction accepted this cycle when `in_valid && in_ready`
- `in_instr`  in  32  fields: opcode [31:26], rd [25:21], rs1 [20:16], rs2 [15:11], imm16 [15:0]
- `in_pc`  in  32  PC of `in_instr`
- `rf_ra`, `rf_rb`  out  5  register file read selects
- `rf_bus_a`, `rf_bus_b`  in  32  register file read data
- `wb_we`, `wb_rw`, `wb_data`  in  1/5/32  writeback port (same signals drive the register file write)
- `flush`  in  1  kill the output slot (branch redirect)
- `out_valid`  out  1  output slot holds an instruction
- `out_ready`  in  1  execute accepts the slot
- `out_pc`  out  32  PC of the slot instruction
- `out_opcode`  out  6  opcode of the slot instruction
- `out_rd`  out  5  destination register
- `out_a`, `out_b`, `out_imm`  out  32  operands; `out_imm` = sign-extended imm16

## Operation
- `rf_ra` = `in_instr`[20:16]; `rf_rb` = `in_instr`[15:11]. Both are combinational and driven regardless of `in_valid`.
- Operand select for each source s:
  - s==0 → 0.
  - Else if `wb_we` && `wb_rw`==s → `wb_data` (bypass).
  - Else → register file bus.
- Register file read buses are valid only in cycles where `wb_we`=0.
- rd==0 means the instruction writes no register (stores, branches). Every instruction is treated as reading both rs1 and rs2.
- pending[r] = scoreboard[r] | (`out_valid` && `out_rd`==r). r=0 is never pending.
- Stall (hazard) if any of these holds:
  - RAW: a nonzero source is pending and not being written this cycle (`wb_we` && `wb_rw`==s).
  - WAW: rd!=0 and rd is pending and not being written this cycle.
  - Read-hold: `wb_we`=1 and a nonzero source ≠ `wb_rw`.
- `in_ready` = !hazard && !flush && (!`out_valid` || `out_ready`). The hazard terms are evaluated only from current inputs and state.
- Accept: load the slot with pc, opcode, rd, selected operands and imm; set `out_valid`=1.
- Handoff (`out_valid` && `out_ready`) without a new accept clears `out_valid`.
- Scoreboard, 32 bits:
  - Set bit `out_rd` on handoff when `out_rd`!=0.
  - Clear bit `wb_rw` when `wb_we` && `wb_rw`!=0.
  - Set and clear of the same bit on the same edge → bit ends set.
- `flush`:
  - Clears `out_valid` on the next edge and blocks accept that cycle.
  - Does not touch the scoreboard (handed-off instructions still write back).
  - A handoff coinciding with flush still sets its scoreboard bit.

## Timing
- Reset: `out_valid`=0, scoreboard=0. `out_pc`, `out_opcode`, `out_rd`, `out_a`, `out_b`, `out_imm` = 0.
- `in_ready` is low during reset.
- Latency: accept at edge N → slot outputs valid after edge N. The writeback bypass applies in the same cycle as the write.
- Slot outputs are stable while `out_valid` && !`out_ready`.
- Full throughput: one instruction per cycle when there is no hazard and `out_ready`=1.
- A RAW stall resolves in the cycle the producer writes back: the value is captured via bypass in that cycle, with no extra bubble.
- Reset mid-stall drops the slot and clears all scoreboard bits.

## Test plan
- Register file holds r1=7, r2=9. Instruction rd=5, rs1=1, rs2=2 with `wb_we`=0 → `in_ready`=1; next cycle `out_a`=7, `out_b`=9, `out_rd`=5, `out_valid`=1.
- rs1=1, rs2=0 with `wb_we`=1, `wb_rw`=1, `wb_data`=0x55 → accepted; `out_a`=0x55, `out_b`=0.
- Read-hold: rs1=1 while wb writes r4 → `in_ready`=0 for that cycle. Next cycle (`wb_we`=0) the instruction is captured with the register file value.
- RAW: issue rd=6; next instruction reads r6 → `in_ready`=0 until `wb_we`=1, `wb_rw`=6, `wb_data`=0x1234 (3 cycles later). It is accepted in that cycle with `out_a`=0x1234, and scoreboard[6] is clear afterwards.
- Backpressure: `out_ready`=0 for 4 cycles → outputs constant and `in_ready`=0. Then WAW: a second rd=6 while r6 is pending stalls until the r6 writeback.
- `flush`=1 with `in_valid`=1 → `out_valid`=0 next cycle and the instruction is not accepted. `reset` during a RAW stall → all outputs return to reset values and the scoreboard is zero.
